// File: rtl/clk_div_pkg.sv
// Shared constants and types for the programmable clock divider.
package clk_div_pkg;

  localparam int unsigned DIV_W_DEFAULT = 8;
  localparam int unsigned DIV_MIN       = 2;

  typedef logic [DIV_W_DEFAULT-1:0] div_t;

endpackage

// File: rtl/div_cfg_shadow.sv
// Shadow register for a requested divide ratio: validates loads, holds the pending value
// until the divider applies it, and reports rejected loads and applied ratios.
module div_cfg_shadow
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DIV_W-1:0] req_div,
  input  logic             apply,
  output logic [DIV_W-1:0] pend_div,
  output logic             pend_valid,
  output logic             cfg_err,
  output logic             div_ack
);

  logic req_ok;

  assign req_ok = (req_div >= DIV_W'(DIV_MIN));

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_div   <= '0;
      pend_valid <= 1'b0;
      cfg_err    <= 1'b0;
      div_ack    <= 1'b0;
    end else begin
      cfg_err <= load & ~req_ok;
      div_ack <= apply;
      // A load coinciding with an apply is kept for the next boundary.
      if (load && req_ok) begin
        pend_div   <= req_div;
        pend_valid <= 1'b1;
      end else if (apply) begin
        pend_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/prog_clock_divider.sv
// Runtime-programmable 50%-duty integer clock divider with glitch-free ratio reload,
// glitch-free enable/park and a period-start tick.
module prog_clock_divider
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W       = DIV_W_DEFAULT,
  parameter int unsigned DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             div_load_i,
  output logic             div_ack_o,
  output logic             cfg_err_o,
  output logic [DIV_W-1:0] div_cur_o,
  output logic             tick_o,
  output logic             clk_div_o
);

  if (DEFAULT_DIV < DIV_MIN || 64'(DEFAULT_DIV) >= (64'(1) << DIV_W)) begin : g_bad_default
    $error("prog_clock_divider: DEFAULT_DIV out of range for DIV_W");
  end

  localparam logic [DIV_W-1:0] DefDiv = DIV_W'(DEFAULT_DIV);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] pend_div;
  logic             pend_valid;
  logic             pos_q, pos_d;
  logic             neg_q;
  logic             tick_q;
  logic             at_last, wrap, parked, apply;

  div_cfg_shadow #(
    .DIV_W (DIV_W)
  ) u_cfg_shadow (
    .clk        (clk),
    .rst        (rst),
    .load       (div_load_i),
    .req_div    (div_i),
    .apply      (apply),
    .pend_div   (pend_div),
    .pend_valid (pend_valid),
    .cfg_err    (cfg_err_o),
    .div_ack    (div_ack_o)
  );

  always_comb begin
    at_last = (cnt_q == div_q - 1'b1);
    wrap    = at_last & en_i;
    parked  = at_last & ~en_i;
    apply   = pend_valid & at_last;
    div_d   = apply ? pend_div : div_q;
    if (wrap) begin
      cnt_d = '0;
    end else if (parked) begin
      // Re-park on the last count of the (possibly new) ratio.
      cnt_d = div_d - 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    pos_d = (cnt_d < (div_d >> 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= DefDiv - 1'b1;
      div_q  <= DefDiv;
      pos_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      pos_q  <= pos_d;
      tick_q <= wrap;
    end
  end

  // Odd ratios stretch the high phase by half a source cycle.
  always_ff @(negedge clk) begin
    if (rst) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= div_q[0] & pos_q;
    end
  end

  assign div_cur_o = div_q;
  assign tick_o    = tick_q;
  assign clk_div_o = pos_q | neg_q;

endmodule

// File: tb/tb_prog_clock_divider.sv
// Self-checking bench: a period-level model predicts the divided waveform half-cycle by
// half-cycle, plus literal event counts for each directed scenario.
module tb_prog_clock_divider;
  import clk_div_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en_i = 1'b0;
  div_t div_i = '0;
  logic div_load_i = 1'b0;
  logic div_ack_o, cfg_err_o, tick_o, clk_div_o;
  div_t div_cur_o;

  int checks = 0;
  int fails  = 0;
  int tick_cnt = 0, ack_cnt = 0, err_cnt = 0, hi_cnt = 0;

  // Model: active ratio, pending ratio, cycles left to the next boundary, expected waveform.
  int m_n = 4, m_pend = 0, m_left = 0;
  bit m_pend_v = 1'b0;
  bit e_tick = 1'b0, e_ack = 1'b0, e_err = 1'b0;
  bit wave[$];
  bit s_rst, s_en, s_ld, ex_p, ex_n;
  int s_div;

  prog_clock_divider #(
    .DIV_W       (8),
    .DEFAULT_DIV (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en_i       (en_i),
    .div_i      (div_i),
    .div_load_i (div_load_i),
    .div_ack_o  (div_ack_o),
    .cfg_err_o  (cfg_err_o),
    .div_cur_o  (div_cur_o),
    .tick_o     (tick_o),
    .clk_div_o  (clk_div_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    s_rst = rst;
    s_en  = en_i;
    s_ld  = div_load_i;
    s_div = int'(div_i);
    if (s_rst) begin
      m_n = 4; m_pend_v = 1'b0; m_left = 0;
      wave.delete();
      e_tick = 1'b0; e_ack = 1'b0; e_err = 1'b0;
    end else begin
      e_tick = 1'b0;
      e_ack  = m_pend_v && (m_left == 0);
      if (m_left == 0) begin
        if (e_ack) begin
          m_n = m_pend;
          m_pend_v = 1'b0;
        end
        if (s_en) begin
          // A period is N half-cycles high then N half-cycles low.
          e_tick = 1'b1;
          m_left = m_n - 1;
          for (int i = 0; i < 2 * m_n; i++) wave.push_back(i < m_n);
        end
      end else begin
        m_left--;
      end
      e_err = s_ld && (s_div < 2);
      if (s_ld && s_div >= 2) begin
        m_pend = s_div;
        m_pend_v = 1'b1;
      end
    end
    #1;
    chk("tick", tick_o, e_tick);
    chk("ack", div_ack_o, e_ack);
    chk("cfg_err", cfg_err_o, e_err);
    chk("div_cur", div_cur_o, m_n);
    ex_p = (wave.size() > 0) ? wave.pop_front() : 1'b0;
    chk("clk_div_pos", clk_div_o, ex_p);
    if (tick_o) tick_cnt++;
    if (div_ack_o) ack_cnt++;
    if (cfg_err_o) err_cnt++;
    if (clk_div_o) hi_cnt++;
  end

  always @(negedge clk) begin
    #1;
    ex_n = (wave.size() > 0) ? wave.pop_front() : 1'b0;
    if (!rst) chk("clk_div_neg", clk_div_o, ex_n);
    if (clk_div_o) hi_cnt++;
  end

  // Inputs set now are sampled at the next posedge; returns 3 time units after it.
  task automatic drive(input logic e, input logic l, input div_t d);
    en_i = e;
    div_load_i = l;
    div_i = d;
    @(posedge clk);
    #3;
  endtask

  task automatic cyc(input int n);
    repeat (n) drive(en_i, 1'b0, '0);
  endtask

  task automatic clr();
    tick_cnt = 0; ack_cnt = 0; err_cnt = 0; hi_cnt = 0;
  endtask

  task automatic sync_wrap();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      drive(en_i, 1'b0, '0);
      seen = (tick_o === 1'b1);
    end
    chk("sync_wrap_timeout", seen, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) drive(1'b0, 1'b0, '0);
    chk("reset_div_cur", div_cur_o, 4);
    chk("reset_clk_div", clk_div_o, 0);

    // Default divide-by-4 straight out of reset.
    rst = 1'b0;
    clr();
    drive(1'b1, 1'b0, '0);
    chk("first_rise_clk", clk_div_o, 1);
    chk("first_rise_tick", tick_o, 1);
    cyc(15);
    chk("div4_ticks", tick_cnt, 4);
    chk("div4_high_halves", hi_cnt, 16);

    // Switch to divide-by-3 while running.
    clr();
    drive(1'b1, 1'b1, 8'd3);
    drive(1'b1, 1'b0, '0);
    cyc(6);
    chk("div3_acks", ack_cnt, 1);
    chk("div3_cur", div_cur_o, 3);
    clr();
    cyc(12);
    chk("div3_ticks", tick_cnt, 4);
    chk("div3_high_halves", hi_cnt, 12);

    // Illegal ratios are rejected.
    clr();
    drive(1'b1, 1'b1, 8'd1);
    drive(1'b1, 1'b1, 8'd0);
    drive(1'b1, 1'b0, '0);
    cyc(4);
    chk("bad_load_errs", err_cnt, 2);
    chk("bad_load_acks", ack_cnt, 0);
    chk("bad_load_cur", div_cur_o, 3);

    // Two loads inside one period: the last one wins.
    sync_wrap();
    clr();
    drive(1'b1, 1'b1, 8'd7);
    drive(1'b1, 1'b1, 8'd5);
    drive(1'b1, 1'b0, '0);
    cyc(3);
    chk("last_write_acks", ack_cnt, 1);
    chk("last_write_cur", div_cur_o, 5);

    // Stop mid high phase with N=6: the period completes, then the output parks low.
    drive(1'b1, 1'b1, 8'd6);
    drive(1'b1, 1'b0, '0);
    cyc(6);
    chk("div6_cur", div_cur_o, 6);
    sync_wrap();
    clr();
    drive(1'b0, 1'b0, '0);
    cyc(10);
    chk("park_high_halves", hi_cnt, 5);
    chk("park_ticks", tick_cnt, 0);
    chk("park_low", clk_div_o, 0);
    drive(1'b1, 1'b0, '0);
    chk("restart_tick", tick_o, 1);
    chk("restart_clk", clk_div_o, 1);
    cyc(3);

    // Maximum ratio, a load left pending, then reset mid-period.
    drive(1'b1, 1'b1, 8'd255);
    drive(1'b1, 1'b0, '0);
    cyc(8);
    chk("div255_cur", div_cur_o, 255);
    drive(1'b1, 1'b1, 8'd9);
    drive(1'b1, 1'b0, '0);
    cyc(50);
    rst = 1'b1;
    drive(1'b1, 1'b0, '0);
    chk("rst_clk_div", clk_div_o, 0);
    chk("rst_tick", tick_o, 0);
    chk("rst_div_cur", div_cur_o, 4);
    drive(1'b1, 1'b0, '0);
    rst = 1'b0;
    clr();
    drive(1'b1, 1'b0, '0);
    cyc(15);
    chk("post_rst_ticks", tick_cnt, 4);
    chk("post_rst_high_halves", hi_cnt, 16);
    chk("post_rst_acks", ack_cnt, 0);
    chk("post_rst_cur", div_cur_o, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
